// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, T-state encoding and opcode legality.
package cpu_ctrl_pkg;

  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned IR_W      = 32;

  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4,
    ST_T5, ST_T6, ST_T7, ST_T8, ST_HALTED
  } tstate_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_OR) || (op == OP_MUL) || (op == OP_DIV) ||
           (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/reg_select_encode.sv
// Turns Gra/Grb/Grc + Rin/Rout/BAout strobes and the IR register fields into
// one-hot register load/drive enables.
module reg_select_encode
  import cpu_ctrl_pkg::*;
(
  input  logic [IR_W-1:0]      ir,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 rin,
  input  logic                 rout,
  input  logic                 baout,
  output logic [REG_COUNT-1:0] r_in,
  output logic [REG_COUNT-1:0] r_out
);

  logic [REG_IDX_W-1:0] sel;
  logic                 ir_unused;

  assign ir_unused = ^{ir[IR_W-1:OP_LSB], ir[RC_LSB-1:0]};

  // BAout reads R0 as constant zero, so no register drives the bus then
  always_comb begin
    sel   = '0;
    r_in  = '0;
    r_out = '0;
    if (gra)      sel = ir[RA_LSB +: REG_IDX_W];
    else if (grb) sel = ir[RB_LSB +: REG_IDX_W];
    else if (grc) sel = ir[RC_LSB +: REG_IDX_W];
    if (rin) r_in[sel] = 1'b1;
    if (rout || (baout && (sel != '0))) r_out[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute T-state sequencer for the 32-bit bus datapath,
// with a memory-handshake watchdog and sticky illegal/mem_error flags.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [IR_W-1:0]      ir,
  input  logic                 mem_ready,
  output logic                 PCout,
  output logic                 PCin,
  output logic                 IncPC,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 Cout,
  output logic                 Read,
  output logic                 Write,
  output logic [OP_W-1:0]      alu_op,
  output logic [REG_COUNT-1:0] r_in,
  output logic [REG_COUNT-1:0] r_out,
  output logic                 running,
  output logic                 illegal,
  output logic                 mem_error
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  tstate_e          state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [OP_W-1:0]  op;
  logic is_rtype, is_addr, is_muldiv, is_wait, timeout;
  logic set_illegal, set_timeout;
  logic gra, grb, grc, rin, rout, baout;

  assign op        = ir[OP_LSB +: OP_W];
  assign is_rtype  = (op >= OP_ADD) && (op <= OP_OR);
  assign is_addr   = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_wait   = (state == ST_T2) || ((state == ST_T7) && (op == OP_LD)) ||
                     ((state == ST_T8) && (op == OP_ST));
  assign timeout   = !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign running   = (state != ST_IDLE) && (state != ST_HALTED);

  // state, watchdog counter and sticky flags
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      illegal   <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (is_wait && !mem_ready) ? wait_cnt + CNT_W'(1) : '0;
      if (set_illegal) illegal   <= 1'b1;
      if (set_timeout) mem_error <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin} = '0;
    {Zin, Zlowout, Zhighout, HIin, LOin, Cout, Read, Write} = '0;
    alu_op = '0;
    {gra, grb, grc, rin, rout, baout} = '0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    // gating on clear keeps every strobe low while reset is held
    if (clear) begin
      case (state)
        ST_IDLE: if (start) next_state = ST_T0;
        ST_T0: begin
          {PCout, MARin, IncPC, Zin} = '1;
          next_state = ST_T1;
        end
        ST_T1: begin
          {Zlowout, PCin} = '1;
          next_state = ST_T2;
        end
        ST_T2: begin
          Read = 1'b1;
          if (mem_ready) begin
            MDRin = 1'b1;
            next_state = ST_T3;
          end else if (timeout) begin
            set_timeout = 1'b1;
            next_state = ST_HALTED;
          end
        end
        ST_T3: begin
          {MDRout, IRin} = '1;
          next_state = ST_T4;
        end
        ST_T4: begin
          if (is_rtype || is_addr || is_muldiv) begin
            Yin = 1'b1;
            next_state = ST_T5;
            if (is_muldiv) {gra, rout} = '1;
            else if (is_rtype) {grb, rout} = '1;
            else {grb, baout} = '1;
          end else if (op == OP_HALT) begin
            next_state = ST_HALTED;
          end else begin
            set_illegal = !op_legal(op);
            next_state = ST_T0;
          end
        end
        ST_T5: begin
          Zin = 1'b1;
          next_state = ST_T6;
          if (is_addr) begin
            Cout   = 1'b1;
            alu_op = OP_ADD;
          end else begin
            alu_op = op;
            rout   = 1'b1;
            if (is_muldiv) grb = 1'b1;
            else grc = 1'b1;
          end
        end
        ST_T6: begin
          Zlowout = 1'b1;
          next_state = ST_T0;
          if ((op == OP_LD) || (op == OP_ST)) begin
            MARin = 1'b1;
            next_state = ST_T7;
          end else if (is_muldiv) begin
            LOin = 1'b1;
            next_state = ST_T7;
          end else begin
            {gra, rin} = '1;
          end
        end
        ST_T7: begin
          next_state = ST_T0;
          if (op == OP_LD) begin
            Read = 1'b1;
            next_state = ST_T7;
            if (mem_ready) begin
              MDRin = 1'b1;
              next_state = ST_T8;
            end else if (timeout) begin
              set_timeout = 1'b1;
              next_state = ST_HALTED;
            end
          end else if (op == OP_ST) begin
            {gra, rout, MDRin} = '1;
            next_state = ST_T8;
          end else begin
            {Zhighout, HIin} = '1;
          end
        end
        ST_T8: begin
          next_state = ST_T0;
          if (op == OP_ST) begin
            Write = 1'b1;
            if (!mem_ready) begin
              next_state = ST_T8;
              if (timeout) begin
                set_timeout = 1'b1;
                next_state = ST_HALTED;
              end
            end
          end else begin
            {MDRout, gra, rin} = '1;
          end
        end
        ST_HALTED: next_state = ST_HALTED;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  reg_select_encode u_sel (
    .ir    (ir),
    .gra   (gra),
    .grb   (grb),
    .grc   (grc),
    .rin   (rin),
    .rout  (rout),
    .baout (baout),
    .r_in  (r_in),
    .r_out (r_out)
  );

  a_one_bus_driver: assert property (@(posedge clock) disable iff (!clear)
    $onehot0({PCout, MDRout, Zlowout, Zhighout, Cout, |r_out}));
  a_onehot_rin:  assert property (@(posedge clock) disable iff (!clear) $onehot0(r_in));
  a_onehot_rout: assert property (@(posedge clock) disable iff (!clear) $onehot0(r_out));

endmodule
